// File: rtl/conv_y_requant_fifo_pkg.sv
// Shared defaults and the requantization arithmetic for the conv y output stage.
package conv_y_requant_fifo_pkg;

  localparam int ACC_SIZE_DEF  = 21;
  localparam int OUT_WIDTH_DEF = 8;
  // Working width for the requant arithmetic; wide enough for any sane ACC_SIZE.
  localparam int MAXW          = 64;

  typedef struct packed {
    logic                   sat;  // clamping to the output range changed the value
    logic signed [MAXW-1:0] q;    // result, already inside the OUT_WIDTH range
  } requant_t;

  // Round half up, arithmetic shift, optional ReLU, saturate to out_w signed bits.
  function automatic requant_t requant(input logic signed [MAXW-1:0] acc,
                                       input int                     shift,
                                       input int                     out_w,
                                       input bit                     relu);
    requant_t               res;
    logic signed [MAXW-1:0] t;
    logic signed [MAXW-1:0] r;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    t  = acc + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0);
    r  = t >>> shift;
    if (relu && (r < 0)) r = '0;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.sat = 1'b0;
    res.q   = r;
    if (r > hi) begin
      res.q   = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.q   = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_y_requant_fifo_if.sv
// Valid/ready bundle: y samples in from the conv core, requantized samples out.
interface conv_y_requant_fifo_if
  import conv_y_requant_fifo_pkg::*;
#(
  parameter int ACC_SIZE  = ACC_SIZE_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
  logic                        s_valid_y;
  logic signed [ACC_SIZE-1:0]  s_data_in_y;
  logic                        s_ready_y;
  logic                        m_valid_q;
  logic                        m_ready_q;
  logic signed [OUT_WIDTH-1:0] m_data_out_q;
  logic                        m_last_q;

  // Environment side: produces y samples, consumes requantized samples.
  modport master (
    output s_valid_y, s_data_in_y, m_ready_q,
    input  s_ready_y, m_valid_q, m_data_out_q, m_last_q
  );

  // Requant FIFO side.
  modport slave (
    input  s_valid_y, s_data_in_y, m_ready_q,
    output s_ready_y, m_valid_q, m_data_out_q, m_last_q
  );
endinterface

// File: rtl/conv_y_requant_fifo_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; head entry shown combinationally.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop;

  // Next-state for pointers, occupancy and flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    push     = wr_en_i && !full_q;
    pop      = rd_en_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the empty flag already masks stale entries.
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/conv_y_requant_fifo.sv
// Requantizes the conv y stream, tags frame ends and buffers results in a small FIFO.
module conv_y_requant_fifo
  import conv_y_requant_fifo_pkg::*;
#(
  parameter int ACC_SIZE  = ACC_SIZE_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT     = 8,
  parameter int RELU      = 1,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 97
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_y_requant_fifo_if.slave  bus,
  output logic                  sat_flag
);
  localparam int FCNT_W = $clog2(FRAME_LEN);

  requant_t             req_s;
  logic                 unused_hi;
  logic                 wr_fire;
  logic                 last_w;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OUT_WIDTH:0]   wr_data;
  logic [OUT_WIDTH:0]   rd_data;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic                 sat_q, sat_d;

  // Requantize the incoming sample (sign-extended into the working width).
  always_comb begin
    req_s = requant({{(MAXW-ACC_SIZE){bus.s_data_in_y[ACC_SIZE-1]}}, bus.s_data_in_y},
                    SHIFT, OUT_WIDTH, RELU != 0);
  end

  // Upper bits are redundant sign copies after saturation.
  assign unused_hi = ^req_s.q[MAXW-1:OUT_WIDTH];

  assign wr_fire = bus.s_valid_y && bus.s_ready_y;
  assign last_w  = (fcnt_q == FCNT_W'(FRAME_LEN - 1));
  assign wr_data = {last_w, req_s.q[OUT_WIDTH-1:0]};

  // Frame position and sticky saturation flag advance on accepted writes.
  always_comb begin
    fcnt_d = fcnt_q;
    sat_d  = sat_q;
    if (wr_fire) begin
      fcnt_d = last_w ? '0 : fcnt_q + FCNT_W'(1);
      if (req_s.sat) sat_d = 1'b1;
    end
  end

  // Frame counter and saturation flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      sat_q  <= sat_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (bus.s_valid_y),
    .wr_data_i (wr_data),
    .full_o    (fifo_full),
    .rd_en_i   (bus.m_ready_q),
    .rd_data_o (rd_data),
    .empty_o   (fifo_empty)
  );

  assign bus.s_ready_y                    = !fifo_full;
  assign bus.m_valid_q                    = !fifo_empty;
  assign {bus.m_last_q, bus.m_data_out_q} = rd_data;
  assign sat_flag                         = sat_q;
endmodule

// File: tb/tb_conv_y_requant_fifo.sv
// Directed bench for conv_y_requant_fifo: one ReLU instance, one signed-pass instance.
module tb_conv_y_requant_fifo;
  localparam int ACC = 21;
  localparam int OW  = 8;
  localparam int FL  = 97;

  logic clk;
  logic reset;
  logic sat_flag;
  logic sat_flag_nr;
  int   checks;
  int   errors;

  conv_y_requant_fifo_if #(.ACC_SIZE(ACC), .OUT_WIDTH(OW)) bus ();
  conv_y_requant_fifo_if #(.ACC_SIZE(ACC), .OUT_WIDTH(OW)) bus_nr ();

  conv_y_requant_fifo #(
    .ACC_SIZE(ACC), .OUT_WIDTH(OW), .SHIFT(8), .RELU(1), .DEPTH(4), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .sat_flag(sat_flag)
  );

  conv_y_requant_fifo #(
    .ACC_SIZE(ACC), .OUT_WIDTH(OW), .SHIFT(8), .RELU(0), .DEPTH(4), .FRAME_LEN(FL)
  ) dut_nr (
    .clk(clk), .reset(reset), .bus(bus_nr), .sat_flag(sat_flag_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    bus.s_valid_y    = 1'b0;
    bus.s_data_in_y  = '0;
    bus.m_ready_q    = 1'b0;
    bus_nr.s_valid_y = 1'b0;
    bus_nr.s_data_in_y = '0;
    bus_nr.m_ready_q = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Single sample through an empty FIFO with the consumer ready; returns the head seen one edge later.
  task automatic xfer(input int v, input bit use_nr, output int d, output logic vld);
    if (use_nr) begin
      bus_nr.s_valid_y = 1'b1; bus_nr.s_data_in_y = ACC'(v); bus_nr.m_ready_q = 1'b1;
    end else begin
      bus.s_valid_y = 1'b1; bus.s_data_in_y = ACC'(v); bus.m_ready_q = 1'b1;
    end
    @(negedge clk);
    bus.s_valid_y    = 1'b0;
    bus_nr.s_valid_y = 1'b0;
    vld = use_nr ? bus_nr.m_valid_q : bus.m_valid_q;
    d   = use_nr ? int'(bus_nr.m_data_out_q) : int'(bus.m_data_out_q);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.s_ready_y !== 1'b1 || bus.m_valid_q !== 1'b0 || bus.m_data_out_q !== 8'h00 ||
        bus.m_last_q !== 1'b0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b sat=%b, want 1 0 00 0 0",
               bus.s_ready_y, bus.m_valid_q, bus.m_data_out_q, bus.m_last_q, sat_flag);
    end
    checks++;
    if (bus_nr.s_ready_y !== 1'b1 || bus_nr.m_valid_q !== 1'b0 || sat_flag_nr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_nr: got rdy=%b vld=%b sat=%b, want 1 0 0",
               bus_nr.s_ready_y, bus_nr.m_valid_q, sat_flag_nr);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int d; logic vld;
    xfer(300, 1'b0, d, vld);
    checks++;
    if (vld !== 1'b1 || d !== 1) begin
      errors++; $display("FAIL basic_300: got vld=%b data=%0d, want 1 1", vld, d);
    end
    checks++;
    if (sat_flag !== 1'b0 || bus.m_valid_q !== 1'b0) begin
      errors++; $display("FAIL basic_after: got sat=%b vld=%b, want 0 0", sat_flag, bus.m_valid_q);
    end
  endtask

  task automatic test_relu_sat();
    int d; logic vld;
    xfer(-129, 1'b0, d, vld);
    checks++;
    if (vld !== 1'b1 || d !== 0 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL relu_neg: got vld=%b data=%0d sat=%b, want 1 0 0", vld, d, sat_flag);
    end
    xfer(-129, 1'b1, d, vld);
    checks++;
    if (vld !== 1'b1 || d !== -1 || sat_flag_nr !== 1'b0) begin
      errors++; $display("FAIL pass_neg: got vld=%b data=%0d sat=%b, want 1 -1 0", vld, d, sat_flag_nr);
    end
    xfer(-40000, 1'b1, d, vld);
    checks++;
    if (vld !== 1'b1 || d !== -128 || sat_flag_nr !== 1'b1) begin
      errors++; $display("FAIL sat_low: got vld=%b data=%0d sat=%b, want 1 -128 1", vld, d, sat_flag_nr);
    end
  endtask

  task automatic test_sat_high();
    int d; logic vld;
    xfer(40000, 1'b0, d, vld);
    checks++;
    if (vld !== 1'b1 || d !== 127 || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_high: got vld=%b data=%0d sat=%b, want 1 127 1", vld, d, sat_flag);
    end
    xfer(300, 1'b0, d, vld);
    checks++;
    if (d !== 1 || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_sticky: got data=%0d sat=%b, want 1 1", d, sat_flag);
    end
    xfer(-129, 1'b0, d, vld);
    checks++;
    if (d !== 0 || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_sticky2: got data=%0d sat=%b, want 0 1", d, sat_flag);
    end
    do_reset();
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL sat_cleared: got sat=%b, want 0", sat_flag);
    end
  endtask

  task automatic test_full();
    int  accepted;
    bus.m_ready_q = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid_y   = 1'b1;
      bus.s_data_in_y = ACC'((i + 1) * 256);
      checks++;
      if (bus.s_ready_y !== (i < 4)) begin
        errors++; $display("FAIL full_ready_%0d: got %b, want %b", i, bus.s_ready_y, i < 4);
      end
      if (i < 4) @(negedge clk);
    end
    bus.m_ready_q = 1'b1;
    accepted = 0;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus.m_valid_q !== 1'b1 || int'(bus.m_data_out_q) !== j + 1) begin
        errors++;
        $display("FAIL full_drain_%0d: got vld=%b data=%0d, want 1 %0d",
                 j, bus.m_valid_q, bus.m_data_out_q, j + 1);
      end
      if (bus.s_valid_y && bus.s_ready_y) accepted++;
      @(negedge clk);
      if (accepted > 0) bus.s_valid_y = 1'b0;
    end
    checks++;
    if (accepted !== 1 || bus.m_valid_q !== 1'b0) begin
      errors++; $display("FAIL full_fifth: got accepted=%0d vld=%b, want 1 0", accepted, bus.m_valid_q);
    end
  endtask

  // Streams n samples (value i%128 -> q i%128) and checks order and last tags.
  task automatic run_stream(input int n, input bit rnd, input string tag);
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < n && cyc < 5000) begin
      bus.s_valid_y   = (sent < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      bus.s_data_in_y = ACC'((sent % 128) * 256);
      bus.m_ready_q   = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.m_valid_q && bus.m_ready_q) begin
        checks++;
        if (int'(bus.m_data_out_q) !== rcvd % 128) begin
          errors++; $display("FAIL %s_data_%0d: got %0d, want %0d", tag, rcvd, bus.m_data_out_q, rcvd % 128);
        end
        checks++;
        if (bus.m_last_q !== ((rcvd % FL) == FL - 1)) begin
          errors++; $display("FAIL %s_last_%0d: got %b, want %b", tag, rcvd, bus.m_last_q, (rcvd % FL) == FL - 1);
        end
        rcvd++;
      end
      if (bus.s_valid_y && bus.s_ready_y) sent++;
      cyc++;
      @(negedge clk);
    end
    bus.s_valid_y = 1'b0;
    checks++;
    if (rcvd !== n || sent !== n || bus.m_valid_q !== 1'b0) begin
      errors++; $display("FAIL %s_count: got sent=%0d rcvd=%0d vld=%b, want %0d %0d 0",
                         tag, sent, rcvd, bus.m_valid_q, n, n);
    end
  endtask

  task automatic test_frames();
    do_reset();
    run_stream(2 * FL, 1'b1, "frames");
  endtask

  task automatic test_reset_mid();
    bus.m_ready_q = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid_y   = 1'b1;
      bus.s_data_in_y = ACC'(i * 256);
      @(negedge clk);
    end
    bus.s_valid_y = 1'b0;
    checks++;
    if (bus.m_valid_q !== 1'b1) begin
      errors++; $display("FAIL midrst_queued: got vld=%b, want 1", bus.m_valid_q);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.m_valid_q !== 1'b0 || bus.s_ready_y !== 1'b1) begin
      errors++; $display("FAIL midrst_async: got vld=%b rdy=%b, want 0 1", bus.m_valid_q, bus.s_ready_y);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_stream(FL, 1'b0, "midrst");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.s_valid_y = 1'b0; bus.s_data_in_y = '0; bus.m_ready_q = 1'b0;
    bus_nr.s_valid_y = 1'b0; bus_nr.s_data_in_y = '0; bus_nr.m_ready_q = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_relu_sat();
    test_sat_high();
    test_full();
    test_frames();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
